// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the MIPS write-back stage
package wb_pkg;

  typedef logic [63:0] hilo_t;

  localparam hilo_t RESET_HILO = 64'h0;

  localparam logic [1:0] SEL_HILO = 2'd0;
  localparam logic [1:0] SEL_BYTE = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_ALU  = 2'd3;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_read_data;
    hilo_t       product;
    logic [31:0] rt_value;
    logic [4:0]  dest_register;
    logic [1:0]  byte_offset;
    logic        reg_write;
    logic        mem_to_reg;
    logic        hi_write;
    logic        lo_write;
    logic        madd;
    logic        msub;
    logic        hi_or_lo;
    logic        hi_to_reg;
    logic        dont_move;
    logic        move_on_not_zero;
    logic        lb;
    logic        load_extended;
  } wb_reg_t;

  // Priority: HI/LO read, then byte load, then word load, then ALU.
  function automatic logic [1:0] wb_select(input logic hi_to_reg,
                                           input logic mem_to_reg,
                                           input logic lb);
    if (hi_to_reg)             return SEL_HILO;
    else if (mem_to_reg && lb) return SEL_BYTE;
    else if (mem_to_reg)       return SEL_MEM;
    else                       return SEL_ALU;
  endfunction

endpackage

// File: rtl/load_byte_extractor.sv
// rtl/load_byte_extractor.sv - picks one byte of a word and sign/zero-extends it
module load_byte_extractor (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic        sign_extend,
  output logic [31:0] result
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    result   = sign_extend ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
  end

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - MEM/WB register, write-port drive, HI/LO and commit counter
module write_back_unit
  import wb_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemReadData,
  input  logic [63:0] Product,
  input  logic [31:0] RtValue,
  input  logic [4:0]  DestRegister,
  input  logic [1:0]  ByteOffset,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic        Madd,
  input  logic        Msub,
  input  logic        HiOrLo,
  input  logic        HiToReg,
  input  logic        DontMove,
  input  logic        MoveOnNotZero,
  input  logic        Lb,
  input  logic        LoadExtended,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWriteIn,
  output logic        Move,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] RetiredCount
);

  wb_reg_t     wb_q;
  wb_reg_t     capture;
  logic        valid;
  logic        committed;
  hilo_t       hilo;
  hilo_t       hilo_next;
  logic        commit;
  logic [31:0] byte_data;
  logic [31:0] retired;

  assign capture = '{
    alu_result:       ALUResult,
    mem_read_data:    MemReadData,
    product:          Product,
    rt_value:         RtValue,
    dest_register:    DestRegister,
    byte_offset:      ByteOffset,
    reg_write:        RegWrite,
    mem_to_reg:       MemToReg,
    hi_write:         HiWrite,
    lo_write:         LoWrite,
    madd:             Madd,
    msub:             Msub,
    hi_or_lo:         HiOrLo,
    hi_to_reg:        HiToReg,
    dont_move:        DontMove,
    move_on_not_zero: MoveOnNotZero,
    lb:               Lb,
    load_extended:    LoadExtended
  };

  load_byte_extractor u_lbx (
    .word        (wb_q.mem_read_data),
    .offset      (wb_q.byte_offset),
    .sign_extend (wb_q.load_extended),
    .result      (byte_data)
  );

  // A stalled instruction commits on its first edge only; committed blocks repeats.
  assign commit = valid & ~committed;

  always_comb begin
    hilo_next = hilo;
    if (wb_q.madd)                          hilo_next = hilo + wb_q.product;
    else if (wb_q.msub)                     hilo_next = hilo - wb_q.product;
    else if (wb_q.hi_write && wb_q.lo_write) hilo_next = wb_q.product;
    else if (wb_q.hi_write)                 hilo_next = {wb_q.alu_result, hilo[31:0]};
    else if (wb_q.lo_write)                 hilo_next = {hilo[63:32], wb_q.alu_result};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_q      <= '0;
      valid     <= 1'b0;
      committed <= 1'b0;
      hilo      <= RESET_HILO;
      retired   <= 32'h0;
    end else begin
      if (commit) begin
        hilo    <= hilo_next;
        retired <= retired + 32'h1;
      end
      if (!Stall) begin
        wb_q      <= capture;
        valid     <= InValid & ~Flush;
        committed <= 1'b0;
      end else begin
        committed <= valid;
      end
    end
  end

  always_comb begin
    WriteData = wb_q.alu_result;
    unique case (wb_select(wb_q.hi_to_reg, wb_q.mem_to_reg, wb_q.lb))
      SEL_HILO: WriteData = wb_q.hi_or_lo ? hilo[63:32] : hilo[31:0];
      SEL_BYTE: WriteData = byte_data;
      SEL_MEM:  WriteData = wb_q.mem_read_data;
      SEL_ALU:  WriteData = wb_q.alu_result;
      default:  WriteData = wb_q.alu_result;
    endcase
  end

  always_comb begin
    Move = 1'b0;
    if (valid) begin
      if (wb_q.dont_move)             Move = 1'b1;
      else if (wb_q.move_on_not_zero) Move = (wb_q.rt_value != 32'h0);
      else                            Move = (wb_q.rt_value == 32'h0);
    end
  end

  assign WriteRegister = wb_q.dest_register;
  assign RegWriteIn    = valid & wb_q.reg_write;
  assign Hi            = hilo[63:32];
  assign Lo            = hilo[31:0];
  assign RetiredCount  = retired;

endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - directed self-checking bench for write_back_unit
module tb_write_back_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid, Stall, Flush;
  logic [31:0] ALUResult, MemReadData, RtValue;
  logic [63:0] Product;
  logic [4:0]  DestRegister;
  logic [1:0]  ByteOffset;
  logic        RegWrite, MemToReg, HiWrite, LoWrite, Madd, Msub;
  logic        HiOrLo, HiToReg, DontMove, MoveOnNotZero, Lb, LoadExtended;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, Hi, Lo, RetiredCount;
  logic        RegWriteIn, Move;

  int tests_run = 0;
  int failed    = 0;

  write_back_unit dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .ALUResult(ALUResult), .MemReadData(MemReadData), .Product(Product),
    .RtValue(RtValue), .DestRegister(DestRegister), .ByteOffset(ByteOffset),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .Madd(Madd), .Msub(Msub), .HiOrLo(HiOrLo), .HiToReg(HiToReg),
    .DontMove(DontMove), .MoveOnNotZero(MoveOnNotZero), .Lb(Lb),
    .LoadExtended(LoadExtended), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegWriteIn(RegWriteIn), .Move(Move),
    .Hi(Hi), .Lo(Lo), .RetiredCount(RetiredCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    InValid = 0; Stall = 0; Flush = 0;
    ALUResult = 0; MemReadData = 0; Product = 0; RtValue = 0;
    DestRegister = 0; ByteOffset = 0;
    RegWrite = 0; MemToReg = 0; HiWrite = 0; LoWrite = 0; Madd = 0; Msub = 0;
    HiOrLo = 0; HiToReg = 0; DontMove = 0; MoveOnNotZero = 0; Lb = 0; LoadExtended = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    #2;
    tests_run++; if (WriteRegister !== 5'd0) begin failed++; $display("FAIL reset_wreg got=%h exp=0", WriteRegister); end
    tests_run++; if (WriteData !== 32'h0) begin failed++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
    tests_run++; if (RegWriteIn !== 1'b0 || Move !== 1'b0) begin failed++; $display("FAIL reset_ctl got=%b%b exp=00", RegWriteIn, Move); end
    tests_run++; if (Hi !== 32'h0 || Lo !== 32'h0 || RetiredCount !== 32'h0) begin failed++; $display("FAIL reset_state got=%h/%h/%h exp=0/0/0", Hi, Lo, RetiredCount); end
    step();
    step();
    Reset = 0;
  endtask

  task automatic test_addu();
    clear_inputs();
    InValid = 1; RegWrite = 1; DontMove = 1; ALUResult = 32'h12345678; DestRegister = 5'd5;
    step();
    clear_inputs();
    tests_run++; if (WriteRegister !== 5'd5) begin failed++; $display("FAIL addu_wreg got=%0d exp=5", WriteRegister); end
    tests_run++; if (WriteData !== 32'h12345678) begin failed++; $display("FAIL addu_wdata got=%h exp=12345678", WriteData); end
    tests_run++; if (RegWriteIn !== 1'b1 || Move !== 1'b1) begin failed++; $display("FAIL addu_ctl got=%b%b exp=11", RegWriteIn, Move); end
    tests_run++; if (RetiredCount !== 32'd0) begin failed++; $display("FAIL addu_precommit got=%0d exp=0", RetiredCount); end
    step();
    tests_run++; if (RetiredCount !== 32'd1) begin failed++; $display("FAIL addu_retired got=%0d exp=1", RetiredCount); end
  endtask

  task automatic test_lb();
    logic [1:0]  offs [3] = '{2'd3, 2'd2, 2'd1};
    logic        ext  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exp  [3] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      InValid = 1; RegWrite = 1; MemToReg = 1; Lb = 1; DontMove = 1;
      MemReadData = 32'h80FF7F01; ByteOffset = offs[i]; LoadExtended = ext[i];
      ALUResult = 32'hDEADBEEF;
      step();
      tests_run++; if (WriteData !== exp[i]) begin failed++; $display("FAIL lb_%0d got=%h exp=%h", i, WriteData, exp[i]); end
    end
    clear_inputs();
    InValid = 1; RegWrite = 1; MemToReg = 1; MemReadData = 32'hCAFEF00D; DontMove = 1;
    step();
    tests_run++; if (WriteData !== 32'hCAFEF00D) begin failed++; $display("FAIL lw_word got=%h exp=cafef00d", WriteData); end
    clear_inputs();
    step();
    tests_run++; if (RetiredCount !== 32'd5) begin failed++; $display("FAIL lb_retired got=%0d exp=5", RetiredCount); end
  endtask

  task automatic test_hilo_seq();
    clear_inputs();
    InValid = 1; HiWrite = 1; LoWrite = 1; Product = 64'h00000001_FFFFFFFF;
    step();
    clear_inputs();
    InValid = 1; Madd = 1; Product = 64'h1;
    step();
    tests_run++; if (Hi !== 32'h1 || Lo !== 32'hFFFFFFFF) begin failed++; $display("FAIL mult_hilo got=%h_%h exp=00000001_ffffffff", Hi, Lo); end
    clear_inputs();
    InValid = 1; RegWrite = 1; HiToReg = 1; HiOrLo = 1; DontMove = 1;
    step();
    tests_run++; if (WriteData !== 32'h2) begin failed++; $display("FAIL mfhi_data got=%h exp=00000002", WriteData); end
    tests_run++; if (Lo !== 32'h0) begin failed++; $display("FAIL madd_lo got=%h exp=0", Lo); end
    clear_inputs();
    step();
    tests_run++; if (RetiredCount !== 32'd8) begin failed++; $display("FAIL hilo_retired got=%0d exp=8", RetiredCount); end
  endtask

  task automatic test_msub_wrap();
    clear_inputs();
    InValid = 1; HiWrite = 1; LoWrite = 1; Product = 64'h0;
    step();
    clear_inputs();
    InValid = 1; Msub = 1; Product = 64'h1;
    step();
    clear_inputs();
    step();
    tests_run++; if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFFF) begin failed++; $display("FAIL msub_wrap got=%h_%h exp=ffffffff_ffffffff", Hi, Lo); end
    InValid = 1; LoWrite = 1; ALUResult = 32'h00000042;
    step();
    clear_inputs();
    step();
    tests_run++; if (Hi !== 32'hFFFFFFFF || Lo !== 32'h42) begin failed++; $display("FAIL mtlo got=%h_%h exp=ffffffff_00000042", Hi, Lo); end
  endtask

  task automatic test_move();
    logic [31:0] rts  [3] = '{32'd0, 32'd0, 32'd7};
    logic        monz [3] = '{1'b0, 1'b1, 1'b1};
    logic        exp  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      InValid = 1; RegWrite = 1; RtValue = rts[i]; MoveOnNotZero = monz[i];
      step();
      tests_run++; if (Move !== exp[i]) begin failed++; $display("FAIL move_%0d got=%b exp=%b", i, Move, exp[i]); end
    end
    clear_inputs();
    InValid = 1; Flush = 1; RegWrite = 1; DontMove = 1;
    step();
    tests_run++; if (Move !== 1'b0 || RegWriteIn !== 1'b0) begin failed++; $display("FAIL flush_bubble got=%b%b exp=00", Move, RegWriteIn); end
    clear_inputs();
    step();
    tests_run++; if (RetiredCount !== 32'd14) begin failed++; $display("FAIL move_retired got=%0d exp=14", RetiredCount); end
  endtask

  task automatic test_stall_commit();
    clear_inputs();
    InValid = 1; HiWrite = 1; LoWrite = 1; Product = 64'h10;
    step();
    clear_inputs();
    InValid = 1; Madd = 1; Product = 64'h5; DestRegister = 5'd9;
    step();
    clear_inputs();
    Stall = 1; Flush = 1; InValid = 1; Madd = 1; Product = 64'd100; DestRegister = 5'd3;
    for (int i = 0; i < 4; i++) step();
    tests_run++; if (Lo !== 32'h15 || Hi !== 32'h0) begin failed++; $display("FAIL stall_once got=%h_%h exp=00000000_00000015", Hi, Lo); end
    tests_run++; if (RetiredCount !== 32'd16) begin failed++; $display("FAIL stall_retired got=%0d exp=16", RetiredCount); end
    tests_run++; if (WriteRegister !== 5'd9) begin failed++; $display("FAIL stall_hold got=%0d exp=9", WriteRegister); end
    clear_inputs();
    step();
    step();
    tests_run++; if (Lo !== 32'h15 || RetiredCount !== 32'd16) begin failed++; $display("FAIL stall_release got=%h/%0d exp=15/16", Lo, RetiredCount); end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    InValid = 1; RegWrite = 1; DontMove = 1; ALUResult = 32'hAA; DestRegister = 5'd7;
    step();
    Stall = 1;
    #2;
    Reset = 1;
    #1;
    tests_run++; if (WriteRegister !== 5'd0 || WriteData !== 32'h0) begin failed++; $display("FAIL rst_stall_data got=%0d/%h exp=0/0", WriteRegister, WriteData); end
    tests_run++; if (RegWriteIn !== 1'b0 || Move !== 1'b0) begin failed++; $display("FAIL rst_stall_ctl got=%b%b exp=00", RegWriteIn, Move); end
    tests_run++; if (Hi !== 32'h0 || Lo !== 32'h0 || RetiredCount !== 32'h0) begin failed++; $display("FAIL rst_stall_state got=%h/%h/%0d exp=0/0/0", Hi, Lo, RetiredCount); end
    #1;
    Reset = 0;
    clear_inputs();
    step();
    step();
    tests_run++; if (RetiredCount !== 32'h0) begin failed++; $display("FAIL rst_discard got=%0d exp=0", RetiredCount); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lb();
    test_hilo_seq();
    test_msub_wrap();
    test_move();
    test_stall_commit();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
